// File: rtl/modport_alu_if.sv
// Operand/mode/result bundle for the registered ALU.
// master drives the operands and mode; slave (the ALU) returns the result.
interface modport_alu_if;
  logic [7:0] in_dataA;
  logic [7:0] in_dataB;
  logic [3:0] in_mode;
  logic [7:0] out_data;
  logic       out_cout;

  modport master (
    output in_dataA,
    output in_dataB,
    output in_mode,
    input  out_data,
    input  out_cout
  );

  modport slave (
    input  in_dataA,
    input  in_dataB,
    input  in_mode,
    output out_data,
    output out_cout
  );
endinterface

// File: rtl/modport_alu.sv
// 8-bit, 16-operation ALU with a single registered result stage.
// Synchronous active-low reset clears the result and flag.
module modport_alu (
  input logic           clk,
  input logic           reset_n,
  modport_alu_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_NAND = 4'd8,
    OP_NOR  = 4'd9,
    OP_XNOR = 4'd10,
    OP_SHL  = 4'd11,
    OP_SHR  = 4'd12,
    OP_ROL  = 4'd13,
    OP_ROR  = 4'd14,
    OP_CMP  = 4'd15
  } alu_op_e;

  alu_op_e     op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [8:0]  sum;
  logic [8:0]  diff;
  logic [15:0] prod;
  logic [7:0]  quot;
  logic        div_zero;
  logic [7:0]  res_data;
  logic        res_cout;
  logic [7:0]  data_q;
  logic        cout_q;

  assign op = alu_op_e'(bus.in_mode);
  assign a  = bus.in_dataA;
  assign b  = bus.in_dataB;

  // Shared arithmetic; the 9th bit of diff is the borrow.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    prod     = 16'(a) * 16'(b);
    div_zero = (b == '0);
    quot     = div_zero ? '1 : (a / b);
  end

  always_comb begin
    res_data = '0;
    res_cout = 1'b0;
    unique case (op)
      OP_ADD: begin
        res_data = sum[7:0];
        res_cout = sum[8];
      end
      OP_SUB: begin
        res_data = diff[7:0];
        res_cout = diff[8];
      end
      OP_MUL: begin
        res_data = prod[7:0];
        res_cout = |prod[15:8];
      end
      OP_DIV: begin
        res_data = quot;
        res_cout = div_zero;
      end
      OP_AND:  res_data = a & b;
      OP_OR:   res_data = a | b;
      OP_XOR:  res_data = a ^ b;
      OP_NOT:  res_data = ~a;
      OP_NAND: res_data = ~(a & b);
      OP_NOR:  res_data = ~(a | b);
      OP_XNOR: res_data = ~(a ^ b);
      OP_SHL: begin
        res_data = {a[6:0], 1'b0};
        res_cout = a[7];
      end
      OP_SHR: begin
        res_data = {1'b0, a[7:1]};
        res_cout = a[0];
      end
      OP_ROL: begin
        res_data = {a[6:0], a[7]};
        res_cout = a[7];
      end
      OP_ROR: begin
        res_data = {a[0], a[7:1]};
        res_cout = a[0];
      end
      OP_CMP: begin
        res_data = {7'b0, (a == b)};
        res_cout = (a > b);
      end
      default: begin
        res_data = '0;
        res_cout = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
      cout_q <= 1'b0;
    end else begin
      data_q <= res_data;
      cout_q <= res_cout;
    end
  end

  assign bus.out_data = data_q;
  assign bus.out_cout = cout_q;

endmodule

// File: tb/tb_modport_alu.sv
// Directed and random-sequence bench for modport_alu; compares {cout,data}
// one cycle after each operand set is presented.
module tb_modport_alu;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  modport_alu_if bus ();

  modport_alu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got cout=%b data=%h want cout=%b data=%h",
               tag, obs[8], obs[7:0], exp[8], exp[7:0]);
    end
  endtask

  // Independent integer reference: returns {cout, data}.
  function automatic logic [8:0] ref_alu(input logic [7:0] av, input logic [7:0] bv,
                                         input logic [3:0] m);
    int ia;
    int ib;
    int r;
    logic c;
    logic [7:0] x;
    ia = int'(av);
    ib = int'(bv);
    r  = 0;
    c  = 1'b0;
    x  = '0;
    case (m)
      4'd0: begin r = ia + ib; c = (r > 255); r = r % 256; end
      4'd1: begin c = (ia < ib); r = (ia - ib + 256) % 256; end
      4'd2: begin r = ia * ib; c = (r > 255); r = r % 256; end
      4'd3: begin
        if (ib == 0) begin r = 255; c = 1'b1; end
        else r = ia / ib;
      end
      4'd4:  begin x = av & bv;    r = int'(x); end
      4'd5:  begin x = av | bv;    r = int'(x); end
      4'd6:  begin x = av ^ bv;    r = int'(x); end
      4'd7:  r = 255 - ia;
      4'd8:  begin x = av & bv;    r = 255 - int'(x); end
      4'd9:  begin x = av | bv;    r = 255 - int'(x); end
      4'd10: begin x = av ^ bv;    r = 255 - int'(x); end
      4'd11: begin r = (ia * 2) % 256; c = (ia >= 128); end
      4'd12: begin r = ia / 2; c = (ia % 2 == 1); end
      4'd13: begin r = (ia * 2) % 256 + ia / 128; c = (ia >= 128); end
      4'd14: begin r = ia / 2 + (ia % 2) * 128; c = (ia % 2 == 1); end
      default: begin r = (ia == ib) ? 1 : 0; c = (ia > ib); end
    endcase
    return {c, 8'(r)};
  endfunction

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [3:0] m, input logic [7:0] exp_d, input logic exp_c);
    bus.in_dataA = av;
    bus.in_dataB = bv;
    bus.in_mode  = m;
    @(posedge clk);
    #1;
    check(tag, {bus.out_cout, bus.out_data}, {exp_c, exp_d});
  endtask

  logic [7:0] ra;
  logic [7:0] rb;
  logic [3:0] rm;
  logic [8:0] exp_v;

  initial begin
    total = 0;
    bad   = 0;
    reset_n      = 1'b0;
    bus.in_dataA = 8'hFF;
    bus.in_dataB = 8'hFF;
    bus.in_mode  = 4'd0;

    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset", {bus.out_cout, bus.out_data}, 9'h000);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", {bus.out_cout, bus.out_data}, {1'b1, 8'hFE});

    run_op("add_ovf",  8'h80, 8'h80, 4'd0, 8'h00, 1'b1);
    run_op("sub_brw",  8'h05, 8'h07, 4'd1, 8'hFE, 1'b1);
    run_op("sub_ok",   8'h07, 8'h05, 4'd1, 8'h02, 1'b0);
    run_op("mul_ovf",  8'h10, 8'h10, 4'd2, 8'h00, 1'b1);
    run_op("mul_max",  8'h0F, 8'h11, 4'd2, 8'hFF, 1'b0);
    run_op("div",      8'd200, 8'd7, 4'd3, 8'd28, 1'b0);
    run_op("div_zero", 8'h12, 8'h00, 4'd3, 8'hFF, 1'b1);
    run_op("and",      8'hA5, 8'h3C, 4'd4, 8'h24, 1'b0);
    run_op("or",       8'hA5, 8'h3C, 4'd5, 8'hBD, 1'b0);
    run_op("xor",      8'hA5, 8'h3C, 4'd6, 8'h99, 1'b0);
    run_op("not",      8'hA5, 8'h3C, 4'd7, 8'h5A, 1'b0);
    run_op("nand",     8'hA5, 8'h3C, 4'd8, 8'hDB, 1'b0);
    run_op("nor",      8'hA5, 8'h3C, 4'd9, 8'h42, 1'b0);
    run_op("xnor",     8'hA5, 8'h3C, 4'd10, 8'h66, 1'b0);
    run_op("shl",      8'h81, 8'h00, 4'd11, 8'h02, 1'b1);
    run_op("shr",      8'h81, 8'h00, 4'd12, 8'h40, 1'b1);
    run_op("rol",      8'h81, 8'h00, 4'd13, 8'h03, 1'b1);
    run_op("ror",      8'h81, 8'h00, 4'd14, 8'hC0, 1'b1);
    run_op("shl_msb0", 8'h42, 8'h00, 4'd11, 8'h84, 1'b0);
    run_op("cmp_eq",   8'h33, 8'h33, 4'd15, 8'h01, 1'b0);
    run_op("cmp_gt",   8'h40, 8'h20, 4'd15, 8'h00, 1'b1);
    run_op("cmp_lt",   8'h20, 8'h40, 4'd15, 8'h00, 1'b0);

    // Back-to-back random operations with a two-cycle reset pulse mid-stream.
    for (int i = 0; i < 1200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 4'($urandom);
      if (i % 17 == 0) rb = 8'h00;
      if (i % 23 == 0) rb = ra;
      reset_n      = (i == 600 || i == 601) ? 1'b0 : 1'b1;
      bus.in_dataA = ra;
      bus.in_dataB = rb;
      bus.in_mode  = rm;
      exp_v = reset_n ? ref_alu(ra, rb, rm) : 9'h000;
      @(posedge clk);
      #1;
      check(reset_n ? "rand" : "rand_reset", {bus.out_cout, bus.out_data}, exp_v);
    end
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
